// File: rtl/op_queue_requester.sv
// Single-outstanding command front end for an external op queue: checks legality against a
// local occupancy count, issues one queue request, and returns one response per command.
`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

module op_queue_requester #(
  parameter int p_depth     = `TOP_DEPTH,
  parameter int p_ptrwidth  = $clog2(p_depth),
  parameter int p_chanwidth = `TOP_CHANWIDTH,
  parameter int p_timeout   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic [2:0]             cmd_op,
  input  logic [p_ptrwidth-1:0]  cmd_tag,
  input  logic [p_chanwidth-1:0] cmd_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [2:0]             resp_op,
  output logic                   resp_err,
  output logic [p_ptrwidth-1:0]  resp_tag,
  output logic [p_chanwidth-1:0] resp_data,
  output logic                   enq_back_req,
  output logic                   enq_front_req,
  output logic                   deq_front_req,
  output logic                   deq_back_req,
  output logic                   upd_req,
  output logic                   del_req,
  input  logic                   enq_back_cpl,
  input  logic                   enq_front_cpl,
  input  logic                   deq_front_cpl,
  input  logic                   deq_back_cpl,
  input  logic                   upd_cpl,
  input  logic                   del_cpl,
  input  logic [p_ptrwidth-1:0]  enq_back_tag_out,
  input  logic [p_ptrwidth-1:0]  enq_front_tag_out,
  output logic [p_chanwidth-1:0] enq_back_data,
  output logic [p_chanwidth-1:0] enq_front_data,
  output logic [p_chanwidth-1:0] upd_data_in,
  input  logic [p_chanwidth-1:0] deq_front_data,
  input  logic [p_chanwidth-1:0] deq_back_data,
  output logic [p_ptrwidth-1:0]  upd_tag_in,
  output logic [p_ptrwidth-1:0]  del_tag_in,
  output logic                   proto_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] OP_ENQ_BACK  = 3'd0;
  localparam logic [2:0] OP_ENQ_FRONT = 3'd1;
  localparam logic [2:0] OP_DEQ_FRONT = 3'd2;
  localparam logic [2:0] OP_DEQ_BACK  = 3'd3;
  localparam logic [2:0] OP_UPD       = 3'd4;
  localparam logic [2:0] OP_DEL       = 3'd5;

  localparam int TW = $clog2(p_timeout + 1);
  localparam logic [p_ptrwidth:0] CNT_FULL = (p_ptrwidth+1)'(p_depth);
  localparam logic [p_ptrwidth:0] CNT_ONE  = (p_ptrwidth+1)'(1);
  localparam logic [TW-1:0]       TMO_LAST = TW'(p_timeout - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [p_ptrwidth-1:0]  tag_q, tag_d, resp_tag_q, resp_tag_d;
  logic [p_chanwidth-1:0] data_q, data_d, resp_data_q, resp_data_d;
  logic [p_ptrwidth:0]    cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   resp_err_q, resp_err_d;
  logic                   proto_err_q, proto_err_d;
  logic                   rst_q;
  logic [5:0]             orphan_q, orphan_d;

  logic [5:0] req_vec, cpl_vec, stray_vec;
  logic       cmd_fire, own_cpl, expired;
  logic       is_enq, needs_entry, is_illegal, reject, echo_tag;

  assign req_vec   = (state_q == S_ISSUE) ? (6'b000001 << op_q) : 6'b0;
  assign cpl_vec   = {del_cpl, upd_cpl, deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
  assign own_cpl   = |(cpl_vec & req_vec);
  // A completion still owed to an op that reset aborted is absorbed rather than flagged.
  assign stray_vec = cpl_vec & ~req_vec & ~orphan_q;
  assign expired   = (state_q == S_ISSUE) && (tmo_q == TMO_LAST);

  assign cmd_rdy  = (state_q == S_IDLE) && !rst;
  assign cmd_fire = cmd_val && cmd_rdy;

  assign is_enq      = (cmd_op == OP_ENQ_BACK) || (cmd_op == OP_ENQ_FRONT);
  assign is_illegal  = (cmd_op > OP_DEL);
  assign needs_entry = !is_enq && !is_illegal;
  assign echo_tag    = (cmd_op == OP_UPD) || (cmd_op == OP_DEL);
  assign reject      = is_illegal || (is_enq && cnt_q == CNT_FULL) ||
                       (needs_entry && cnt_q == '0);

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    tag_d       = tag_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    resp_err_d  = resp_err_q;
    resp_tag_d  = resp_tag_q;
    resp_data_d = resp_data_q;
    proto_err_d = proto_err_q | (|stray_vec);
    orphan_d    = orphan_q & ~cpl_vec;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d        = cmd_op;
          tag_d       = cmd_tag;
          data_d      = cmd_data;
          tmo_d       = '0;
          orphan_d    = '0;
          resp_err_d  = reject;
          resp_tag_d  = echo_tag ? cmd_tag : '0;
          resp_data_d = '0;
          state_d     = reject ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (own_cpl) begin
          state_d    = S_RESP;
          resp_err_d = 1'b0;
          case (op_q)
            OP_ENQ_BACK:  begin resp_tag_d  = enq_back_tag_out;  cnt_d = cnt_q + CNT_ONE; end
            OP_ENQ_FRONT: begin resp_tag_d  = enq_front_tag_out; cnt_d = cnt_q + CNT_ONE; end
            OP_DEQ_FRONT: begin resp_data_d = deq_front_data;    cnt_d = cnt_q - CNT_ONE; end
            OP_DEQ_BACK:  begin resp_data_d = deq_back_data;     cnt_d = cnt_q - CNT_ONE; end
            OP_DEL:       cnt_d = cnt_q - CNT_ONE;
            default:      cnt_d = cnt_q;
          endcase
        end else if (expired) begin
          state_d    = S_RESP;
          resp_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the same pre-edge values.
    rst_q <= rst;
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      resp_err_q  <= 1'b0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
      proto_err_q <= 1'b0;
      orphan_q    <= rst_q ? orphan_q : req_vec;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      resp_err_q  <= resp_err_d;
      resp_tag_q  <= resp_tag_d;
      resp_data_q <= resp_data_d;
      proto_err_q <= proto_err_d;
      orphan_q    <= orphan_d;
    end
  end

  assign {del_req, upd_req, deq_back_req, deq_front_req, enq_front_req, enq_back_req} = req_vec;

  assign enq_back_data  = data_q;
  assign enq_front_data = data_q;
  assign upd_data_in    = data_q;
  assign upd_tag_in     = tag_q;
  assign del_tag_in     = tag_q;

  assign resp_val  = (state_q == S_RESP);
  assign resp_op   = op_q;
  assign resp_err  = resp_err_q;
  assign resp_tag  = resp_tag_q;
  assign resp_data = resp_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_op_queue_requester.sv
// Self-checking bench for op_queue_requester: directed vector table, hand-written corner
// sequences, and random commands checked against a queue-level reference model.
module tb_op_queue_requester;

  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int CW    = 8;
  localparam int TMO   = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_val, cmd_rdy;
  logic [2:0]    cmd_op;
  logic [PW-1:0] cmd_tag;
  logic [CW-1:0] cmd_data;
  logic          resp_val, resp_rdy, resp_err;
  logic [2:0]    resp_op;
  logic [PW-1:0] resp_tag;
  logic [CW-1:0] resp_data;
  logic          enq_back_req, enq_front_req, deq_front_req, deq_back_req, upd_req, del_req;
  logic [5:0]    cpl;
  logic [PW-1:0] enq_back_tag_out, enq_front_tag_out, upd_tag_in, del_tag_in;
  logic [CW-1:0] enq_back_data, enq_front_data, upd_data_in, deq_front_data, deq_back_data;
  logic          proto_err;
  logic [5:0]    tb_req;

  assign tb_req = {del_req, upd_req, deq_back_req, deq_front_req, enq_front_req, enq_back_req};

  op_queue_requester #(.p_depth(DEPTH), .p_ptrwidth(PW), .p_chanwidth(CW), .p_timeout(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_tag(cmd_tag), .cmd_data(cmd_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_err(resp_err),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .enq_back_req(enq_back_req), .enq_front_req(enq_front_req), .deq_front_req(deq_front_req),
    .deq_back_req(deq_back_req), .upd_req(upd_req), .del_req(del_req),
    .enq_back_cpl(cpl[0]), .enq_front_cpl(cpl[1]), .deq_front_cpl(cpl[2]),
    .deq_back_cpl(cpl[3]), .upd_cpl(cpl[4]), .del_cpl(cpl[5]),
    .enq_back_tag_out(enq_back_tag_out), .enq_front_tag_out(enq_front_tag_out),
    .enq_back_data(enq_back_data), .enq_front_data(enq_front_data), .upd_data_in(upd_data_in),
    .deq_front_data(deq_front_data), .deq_back_data(deq_back_data),
    .upd_tag_in(upd_tag_in), .del_tag_in(del_tag_in), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [PW-1:0] tag;
    logic [CW-1:0] data;
    int            cpl_at;   // req cycle (1-based) in which cpl is driven; 0 = never
    logic [PW-1:0] tag_ret;
    logic [CW-1:0] deq_ret;
    int            stall;    // cycles resp_rdy is held low once resp_val is seen
    logic          exp_err;
    logic [PW-1:0] exp_tag;
    logic [CW-1:0] exp_data;
    int            exp_lat;  // cycles between handshake+1 and resp_val
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input int tag, input int data, input int cpl_at,
                              input int tag_ret, input int deq_ret, input int stall,
                              input int exp_err, input int exp_tag, input int exp_data,
                              input int exp_lat);
    vec_t v;
    v.op = 3'(op); v.tag = PW'(tag); v.data = CW'(data); v.cpl_at = cpl_at;
    v.tag_ret = PW'(tag_ret); v.deq_ret = CW'(deq_ret); v.stall = stall;
    v.exp_err = 1'(exp_err); v.exp_tag = PW'(exp_tag); v.exp_data = CW'(exp_data);
    v.exp_lat = exp_lat;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic run_vec(input vec_t v, input string nm);
    int   guard, lat;
    bit   req_ok, outs_ok, stable_ok;
    logic [2:0] r_op; logic r_err; logic [PW-1:0] r_tag; logic [CW-1:0] r_data;
    guard = 0;
    while (!cmd_rdy && guard < 40) begin @(negedge clk); guard++; end
    check({nm, ".cmd_rdy"}, cmd_rdy, 1);
    cmd_val = 1'b1; cmd_op = v.op; cmd_tag = v.tag; cmd_data = v.data;
    @(negedge clk);
    cmd_val = 1'b0; cmd_op = 3'($urandom); cmd_tag = PW'($urandom); cmd_data = CW'($urandom);
    lat = 0; req_ok = 1; outs_ok = 1;
    while (!resp_val && lat < TMO + 4) begin
      if (tb_req != (6'b000001 << v.op)) req_ok = 0;
      if (enq_back_data != v.data || enq_front_data != v.data || upd_data_in != v.data ||
          upd_tag_in != v.tag || del_tag_in != v.tag) outs_ok = 0;
      lat++;
      if (lat == v.cpl_at) begin
        cpl = 6'b000001 << v.op;
        enq_back_tag_out = v.tag_ret; enq_front_tag_out = v.tag_ret;
        deq_front_data = v.deq_ret; deq_back_data = v.deq_ret;
      end
      @(negedge clk);
      cpl = '0;
      enq_back_tag_out = PW'($urandom); enq_front_tag_out = PW'($urandom);
      deq_front_data = CW'($urandom); deq_back_data = CW'($urandom);
    end
    check({nm, ".resp_val"}, resp_val, 1);
    check({nm, ".latency"}, lat, v.exp_lat);
    check({nm, ".req_held"}, req_ok, 1);
    check({nm, ".req_outs"}, outs_ok, 1);
    check({nm, ".req_low_in_resp"}, tb_req, 0);
    check({nm, ".resp_op"}, resp_op, v.op);
    check({nm, ".resp_err"}, resp_err, v.exp_err);
    check({nm, ".resp_tag"}, resp_tag, v.exp_tag);
    check({nm, ".resp_data"}, resp_data, v.exp_data);
    if (v.stall > 0) begin
      r_op = resp_op; r_err = resp_err; r_tag = resp_tag; r_data = resp_data;
      resp_rdy = 1'b0; stable_ok = 1;
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        if (!resp_val || cmd_rdy || resp_op != r_op || resp_err != r_err ||
            resp_tag != r_tag || resp_data != r_data) stable_ok = 0;
      end
      check({nm, ".stall_stable"}, stable_ok, 1);
      resp_rdy = 1'b1;
    end
    @(negedge clk);
    check({nm, ".back_to_idle"}, cmd_rdy, 1);
  endtask

  vec_t      tbl[16];
  vec_t      v;
  logic [CW-1:0] mq[$];
  int        idx, r, sz;
  bit        legal, done, enq, deq;
  int        op_pick[12] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 0, 1};

  initial begin
    // op, tag, data, cpl_at, tag_ret, deq_ret, stall, exp_err, exp_tag, exp_data, exp_lat
    tbl[0]  = mk(2, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);  // deq_front on empty
    tbl[1]  = mk(0, 0, 8'hA5, 2, 3, 8'h00, 0, 0, 3, 8'h00, 2);  // enq_back, cpl at N+2
    tbl[2]  = mk(4, 2, 8'h11, 1, 0, 8'h00, 0, 0, 2, 8'h00, 1);  // upd
    tbl[3]  = mk(6, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);  // illegal 6
    tbl[4]  = mk(7, 1, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);  // illegal 7
    tbl[5]  = mk(1, 0, 8'h22, 1, 1, 8'h00, 0, 0, 1, 8'h00, 1);  // enq_front
    tbl[6]  = mk(0, 0, 8'h33, 3, 0, 8'h00, 0, 0, 0, 8'h00, 3);
    tbl[7]  = mk(0, 0, 8'h44, 1, 2, 8'h00, 0, 0, 2, 8'h00, 1);  // now full
    tbl[8]  = mk(1, 0, 8'h55, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);  // enq_front on full
    tbl[9]  = mk(0, 0, 8'h66, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);  // enq_back on full
    tbl[10] = mk(3, 0, 8'h00, 1, 0, 8'h5A, 3, 0, 0, 8'h5A, 1);  // deq_back
    tbl[11] = mk(5, 1, 8'h00, 2, 0, 8'h00, 0, 0, 1, 8'h00, 2);  // del
    tbl[12] = mk(2, 0, 8'h00, 1, 0, 8'h77, 0, 0, 0, 8'h77, 1);  // deq_front
    tbl[13] = mk(5, 3, 8'h00, 1, 0, 8'h00, 0, 0, 3, 8'h00, 1);  // del -> empty
    tbl[14] = mk(5, 2, 8'h00, 1, 0, 8'h00, 0, 1, 2, 8'h00, 0);  // del on empty
    tbl[15] = mk(4, 1, 8'h00, 1, 0, 8'h00, 0, 1, 1, 8'h00, 0);  // upd on empty

    rst = 1'b1; cmd_val = 1'b0; cmd_op = '0; cmd_tag = '0; cmd_data = '0; resp_rdy = 1'b1;
    cpl = '0; enq_back_tag_out = '0; enq_front_tag_out = '0;
    deq_front_data = '0; deq_back_data = '0;
    @(negedge clk); @(negedge clk);
    check("rst.cmd_rdy", cmd_rdy, 0);
    check("rst.req", tb_req, 0);
    check("rst.resp_val", resp_val, 0);
    check("rst.resp_fields", {resp_op, resp_err, resp_tag, resp_data}, 0);
    check("rst.proto_err", proto_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.cmd_rdy_after", cmd_rdy, 1);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Timeout: withheld cpl aborts after TMO req cycles and leaves the count alone.
    run_vec(mk(0, 0, 8'h10, 1, 1, 0, 0, 0, 1, 0, 1), "tmo.fill");
    run_vec(mk(4, 2, 8'h20, 0, 0, 0, 0, 1, 2, 0, TMO), "tmo.expire");
    run_vec(mk(4, 2, 8'h21, TMO, 0, 0, 0, 0, 2, 0, TMO), "tmo.cpl_on_expiry");
    run_vec(mk(2, 0, 0, 1, 0, 8'h10, 0, 0, 0, 8'h10, 1), "tmo.drain");
    run_vec(mk(2, 0, 0, 1, 0, 0, 10, 1, 0, 0, 0), "stall10.reject");

    // Random commands against a queue model.
    for (int n = 0; n < 60; n++) begin
      v.op = 3'(op_pick[$urandom_range(0, 11)]);
      v.tag = PW'($urandom); v.data = CW'($urandom); v.tag_ret = PW'($urandom);
      r = int'($urandom_range(0, 9));
      v.cpl_at = (r == 0) ? 0 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : int'($urandom_range(1, 3));
      v.stall = int'($urandom_range(0, 2));
      sz = mq.size();
      enq = (v.op <= 3'd1);
      deq = (v.op == 3'd2) || (v.op == 3'd3);
      v.deq_ret = (v.op == 3'd2 && sz > 0) ? mq[0] : (v.op == 3'd3 && sz > 0) ? mq[sz-1] : CW'($urandom);
      legal = (v.op <= 3'd5) && !(enq && sz == DEPTH) && !(!enq && sz == 0);
      done = legal && v.cpl_at >= 1 && v.cpl_at <= TMO;
      v.exp_err = !done;
      v.exp_lat = !legal ? 0 : done ? v.cpl_at : TMO;
      v.exp_tag = (done && enq) ? v.tag_ret : (v.op == 3'd4 || v.op == 3'd5) ? v.tag : '0;
      v.exp_data = (done && deq) ? v.deq_ret : '0;
      run_vec(v, $sformatf("rnd%0d", n));
      if (done) begin
        case (v.op)
          3'd0: mq.push_back(v.data);
          3'd1: mq.push_front(v.data);
          3'd2: void'(mq.pop_front());
          3'd3, 3'd5: void'(mq.pop_back());
          default: ;
        endcase
      end
    end

    // Stray completion in IDLE is sticky until reset.
    check("proto.before", proto_err, 0);
    cpl = 6'b100000;
    @(negedge clk);
    cpl = '0;
    check("proto.set", proto_err, 1);
    run_vec(mk(7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), "proto.cmd");
    check("proto.sticky", proto_err, 1);

    // Reset in the middle of an issued enq; its late cpl is neither counted nor flagged.
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.proto_cleared", proto_err, 0);
    cmd_val = 1'b1; cmd_op = 3'd0; cmd_data = 8'hC3;
    @(negedge clk);
    cmd_val = 1'b0;
    check("rstmid.req_up", enq_back_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.req_dropped", tb_req, 0);
    check("rstmid.cmd_rdy_in_rst", cmd_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.cmd_rdy", cmd_rdy, 1);
    cpl = 6'b000001; enq_back_tag_out = 2'd1;
    @(negedge clk);
    cpl = '0;
    check("rstmid.late_cpl_proto", proto_err, 0);
    run_vec(mk(2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), "rstmid.still_empty");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/op_queue_requester.md
OP_QUEUE_REQUESTER -- requirements
Module: op_queue_requester

Interface
REQ-001 Parameter p_depth, default `TOP_DEPTH, is the queue entry count, which equals the tag space.
REQ-002 Parameter p_ptrwidth, default $clog2(p_depth), is the tag width.
REQ-003 Parameter p_chanwidth, default `TOP_CHANWIDTH, is the payload width.
REQ-004 Parameter p_timeout, default 64, is the max cycles a queue req is held before abort.
REQ-005 Port clk, in, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, in, 1: synchronous, active-high reset.
REQ-007 Port cmd_val, in, 1 / cmd_rdy, out, 1: upstream command val/rdy handshake.
REQ-008 Port cmd_op, in, 3: command opcode; 0 enq_back, 1 enq_front, 2 deq_front, 3 deq_back, 4 upd, 5 del; 6 and 7 are illegal.
REQ-009 Port cmd_tag, in, p_ptrwidth: target tag for upd/del commands.
REQ-010 Port cmd_data, in, p_chanwidth: payload for enq/upd commands.
REQ-011 Ports resp_val, out, 1 / resp_rdy, in, 1: downstream response val/rdy handshake.
REQ-012 Ports resp_op, out, 3 / resp_err, out, 1: echoed opcode and error flag.
REQ-013 Port resp_tag, out, p_ptrwidth: tag returned by an enq, or the echoed cmd_tag for upd/del.
REQ-014 Port resp_data, out, p_chanwidth: payload returned by a deq; 0 for all other ops.
REQ-015 Ports enq_back_req, enq_front_req, deq_front_req, deq_back_req, upd_req and del_req, out, 1 each: queue op requests, at most one high per cycle.
REQ-016 Ports enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl and del_cpl, in, 1 each: queue completions.
REQ-017 Ports enq_back_tag_out and enq_front_tag_out, in, p_ptrwidth: tags allocated by the queue.
REQ-018 Ports enq_back_data, enq_front_data and upd_data_in, out, p_chanwidth: all three driven from the latched command payload.
REQ-019 Ports deq_front_data and deq_back_data, in, p_chanwidth: dequeued payloads.
REQ-020 Ports upd_tag_in and del_tag_in, out, p_ptrwidth: both driven from the latched command tag.
REQ-021 Port proto_err, out, 1: sticky flag, set on any unexpected completion.

Function
REQ-022 The FSM has three states, IDLE, ISSUE and RESP; cmd_rdy is 1 only in IDLE.
REQ-023 On a cmd_val&&cmd_rdy handshake in cycle N, the block latches op, tag and data and runs a local legality check.
REQ-024 The legality check uses an occupancy counter cnt of width p_ptrwidth+1, range 0..p_depth.
REQ-025 A command is rejected if: it is an enq with cnt==p_depth; it is a deq, upd or del with cnt==0; or its opcode is 6 or 7.
REQ-026 On reject: go to RESP with resp_err=1 and resp_val high in cycle N+1; no queue req is raised.
REQ-027 On accept: go to ISSUE; the selected req rises in cycle N+1; tag and data outputs are stable while req is high.
REQ-028 In ISSUE, the req is held high until its own cpl is sampled high; the req drops the next cycle and the FSM moves to RESP.
REQ-029 On completion, the block captures the relevant enq tag or deq data on the cpl cycle M; resp_val rises at M+1 with resp_err=0.
REQ-030 cnt is updated on completion only: +1 for enq, -1 for deq and del, unchanged for upd.
REQ-031 A timeout counter resets on entry to ISSUE and counts every cycle the req is high.
REQ-032 When the timeout counter reaches p_timeout: drop the req, go to RESP with resp_err=1, and leave cnt unchanged.
REQ-033 If cpl coincides with the timeout-expiry cycle, cpl wins and the op completes normally.
REQ-034 Any cpl sampled high whose req is not high in that cycle sets proto_err and is otherwise ignored; proto_err clears only on rst.
REQ-035 In RESP, the resp_* outputs are held stable until resp_rdy; the FSM returns to IDLE the cycle after resp_val&&resp_rdy.
REQ-036 There is no command pipelining: exactly one op is in flight.
REQ-037 Minimum accepted-op throughput is one per 3 cycles, which requires cpl in cycle N+1 and resp_rdy tied high.

Reset
REQ-038 While rst is high: state goes to IDLE, cnt=0, timeout counter=0, proto_err=0.
REQ-039 Reset values of outputs: all req outputs 0, cmd_rdy 0 during rst and 1 the cycle after, resp_val 0, and resp_op, resp_tag, resp_data and resp_err all 0.
REQ-040 If rst is asserted mid-ISSUE, the req drops the next cycle; a cpl arriving after that is not counted and does not set proto_err.

Verification
REQ-041 enq_back of data 0xA5, with enq_back_cpl and enq_back_tag_out=3 at N+2 -> resp_val at N+3, resp_tag=3, resp_err=0, cnt=1.
REQ-042 deq_front while cnt=0 -> no req raised, resp_val at N+1, resp_err=1, resp_op=2.
REQ-043 Fill to cnt=p_depth, then enq_front -> rejected; then deq_back with deq_back_data=0x5A -> resp_data=0x5A, cnt=p_depth-1.
REQ-044 upd with tag 2 and cpl withheld -> upd_req high for exactly p_timeout cycles, then resp_err=1; cpl on the expiry cycle -> resp_err=0.
REQ-045 del_cpl pulsed while IDLE -> proto_err=1 and persists until rst; resp_rdy held low 10 cycles in RESP -> resp_* stable and cmd_rdy=0 throughout.
